decode_stage: RTL and testbench
===============================

# decode_stage

Integer decode stage of the RV32I core, directly upstream of the ALU. It accepts one instruction per handshake and decodes R-type (OP) and I-type (OP-IMM) arithmetic instructions. It also owns the 32×32 integer register file with a write-back port. One cycle after accepting an instruction it presents registered operands plus `funct3`/`funct7` to the ALU through a valid/ready output register.

## Interface
- `XLEN`, 32: datapath width.
- `NREG`, 32: register count; x0 is hardwired to zero.

- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: `instr` is valid.
- `in_ready` out 1: stage can accept. Equals `!rst && (!out_valid || out_ready)`.
- `instr` in 32: instruction word.
- `wb_en` in 1: register write strobe.
- `wb_addr` in 5: write register index.
- `wb_data` in XLEN: write data.
- `out_valid` out 1: decoded operation is held in the output register.
- `out_ready` in 1: ALU consumes the output this cycle.
- `rs1` out XLEN: operand A.
- `rs2` out XLEN: operand B, either a register value or an immediate.
- `funct3` out 3: ALU operation select.
- `funct7` out 1: ALU alternate-op bit (SUB/SRA).
- `rd_addr` out 5: destination register index.
- `illegal` out 1: one-cycle pulse when an unsupported instruction is accepted.

## Operation
- **Accept:** an instruction is accepted when `in_valid && in_ready`.
  - A legal instruction loads the output register and sets `out_valid`.
  - An illegal instruction is consumed and raises `illegal` for 1 cycle; `out_valid` is not set.
- **Output handshake:** the output is consumed when `out_valid && out_ready`. If no new accept happens in the same cycle, `out_valid` clears.
- **OP (opcode 0110011):**
  - `rs1`/`rs2` = register file reads at `instr[19:15]`/`instr[24:20]`.
  - `funct3` = `instr[14:12]`; `funct7` = `instr[30]`.
  - `instr[31:25]` must be 0000000, or 0100000 with `funct3` ∈ {000, 101}. Anything else is illegal.
- **OP-IMM (opcode 0010011):**
  - `rs1` = register read.
  - `funct3` 001 or 101 (shifts): `rs2` = zero-extended `instr[24:20]`.
    - 001 requires `instr[31:25]` = 0000000; 101 allows 0000000 or 0100000. Anything else is illegal.
    - `funct7` = `instr[30]` for 101, 0 for 001.
  - Other `funct3`: `rs2` = sign-extended `instr[31:20]` (XLEN bits), `funct7` = 0.
- **Other opcodes:** illegal.
- **Register file:**
  - Write on `wb_en` at the clock edge when `wb_addr != 0`; writes to x0 are ignored.
  - Reads of x0 always return 0.
- **Bypass:** if `wb_en` targets a non-zero register that the accepted instruction reads in the same cycle, the captured operand is `wb_data`.
- **Operand freeze:** operands are frozen at capture. A later write-back does not update a held output.
- **Write-back independence:** write-back is accepted every cycle, independent of both handshakes.

## Timing
- **Reset:** after a cycle with `rst`=1:
  - `out_valid`=0, `illegal`=0.
  - `rs1`, `rs2`, `funct3`, `funct7`, `rd_addr` all 0.
  - All registers 0.
  - `in_ready`=0 while `rst` is high.
  - `wb_en` is ignored while `rst` is high.
- **Reset mid-operation:** a pending output is discarded and no handshake completes.
- **Latency:** an accept at edge N drives `out_valid`=1 with fields valid after edge N.
- **Throughput:** one instruction per cycle when `out_ready`=1. Consume and accept may occur in the same cycle.
- **Backpressure:** while `out_valid && !out_ready`, all outputs are stable and `in_ready`=0.
- **`illegal`:** high for exactly the cycle after the accepting edge.

## Test plan
- **Basic ADD:** reset; write x1=20, then x2=30; send ADD x3,x1,x2 (0x002081B3) with `out_ready`=1 → next cycle `out_valid`=1, `rs1`=20, `rs2`=30, `funct3`=000, `funct7`=0, `rd_addr`=3.
- **SUB:** send SUB x3,x1,x2 (0x402081B3) → `funct7`=1, `rs1`=20, `rs2`=30. Then send a word with `instr[31:25]`=0100000 and `funct3`=111 → `illegal` pulse, no `out_valid`.
- **Immediates:**
  - ADDI x5,x1,-1 (0xFFF08293) → `rs2`=0xFFFFFFFF, `funct7`=0.
  - SRAI x5,x1,3 (0x4030D293) → `rs2`=3, `funct3`=101, `funct7`=1.
- **Bypass and x0:**
  - `wb_en` x1=8 in the same cycle as accepting ADD x3,x1,x2 → `rs1`=8.
  - `wb_en` x0=0xDEAD, then ADD x3,x0,x0 → `rs1`=`rs2`=0.
- **Backpressure:** hold `out_ready`=0 for 3 cycles after an accept → `out_valid` and all fields stable, `in_ready`=0. Raise `out_ready` → a second queued instruction is accepted that cycle and appears the next cycle.
- **Illegal and reset:**
  - ECALL (0x00000073) → `illegal`=1 for one cycle, `out_valid` stays 0.
  - Assert `rst` while `out_valid`=1 → next cycle all outputs 0 and x1 reads 0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I integer decode stage: decodes OP / OP-IMM arithmetic instructions, owns the
// 32x32 register file with a write-back port, and presents operands to the ALU.
module decode_stage #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rs1,
   output logic [XLEN-1:0] rs2,
   output logic [2:0]      funct3,
   output logic            funct7,
   output logic [4:0]      rd_addr,
   output logic            illegal
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   logic [XLEN-1:0] regs [NREG];

   logic [6:0]      opcode;
   logic [6:0]      hi;
   logic [2:0]      f3;
   logic [4:0]      rs1_idx;
   logic [4:0]      rs2_idx;
   logic            accept;
   logic            legal;
   logic            alt_bit;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic [XLEN-1:0] opb;

   assign opcode  = instr[6:0];
   assign f3      = instr[14:12];
   assign rs1_idx = instr[19:15];
   assign rs2_idx = instr[24:20];
   assign hi      = instr[31:25];

   assign in_ready = !rst && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Register reads see a same-cycle write-back so back-to-back dependents need no stall.
   always_comb begin
      src1 = '0;
      src2 = '0;
      if (rs1_idx != 5'd0)
         src1 = (wb_en && wb_addr == rs1_idx) ? wb_data : regs[rs1_idx];
      if (rs2_idx != 5'd0)
         src2 = (wb_en && wb_addr == rs2_idx) ? wb_data : regs[rs2_idx];
   end

   always_comb begin
      legal   = 1'b0;
      alt_bit = 1'b0;
      opb     = src2;
      case (opcode)
         OPC_OP: begin
            alt_bit = instr[30];
            legal   = (hi == F7_ZERO) ||
                      (hi == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
         end
         OPC_OPIMM: begin
            if (f3 == 3'b001) begin
               opb   = {{(XLEN-5){1'b0}}, rs2_idx};
               legal = (hi == F7_ZERO);
            end else if (f3 == 3'b101) begin
               opb     = {{(XLEN-5){1'b0}}, rs2_idx};
               alt_bit = instr[30];
               legal   = (hi == F7_ZERO) || (hi == F7_ALT);
            end else begin
               opb   = {{(XLEN-12){instr[31]}}, instr[31:20]};
               legal = 1'b1;
            end
         end
         default: legal = 1'b0;
      endcase
   end

   // Write-back runs every cycle regardless of either handshake; x0 is never written.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (wb_en && wb_addr != 5'd0) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Output register: fields only change on an accept, so a held output stays frozen.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         illegal   <= 1'b0;
         rs1       <= '0;
         rs2       <= '0;
         funct3    <= '0;
         funct7    <= 1'b0;
         rd_addr   <= '0;
      end else begin
         illegal <= accept && !legal;
         if (accept && legal) begin
            out_valid <= 1'b1;
            rs1       <= src1;
            rs2       <= opb;
            funct3    <= f3;
            funct7    <= alt_bit;
            rd_addr   <= instr[11:7];
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; each task drives one scenario and
// compares the packed output bundle against hand-computed values.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [2:0]  funct3;
   logic        funct7;
   logic [4:0]  rd_addr;
   logic        illegal;

   int tests_run = 0;
   int tests_failed = 0;

   // Bundle layout: valid, illegal, funct7, funct3, rd_addr, rs1, rs2
   logic [74:0] obs;
   logic [74:0] exp;
   assign obs = {out_valid, illegal, funct7, funct3, rd_addr, rs1, rs2};

   decode_stage #(.XLEN(32), .NREG(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
      .out_ready(out_ready), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
      .rd_addr(rd_addr), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      wb_en = 1'b1; wb_addr = a; wb_data = d;
      tick();
      wb_en = 1'b0;
   endtask

   task automatic send(input logic [31:0] w);
      in_valid = 1'b1; instr = w;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd55;
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
      tick();
      tick();
      wb_en = 1'b0;
      exp = '0;
      tests_run++;
      if (obs !== exp) begin tests_failed++; $display("[TB] FAIL reset_state: got %h expected %h", obs, exp); end
      rst = 1'b0;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready); end
      // x1 write during reset must have been ignored
      send(32'h000081B3);
      exp = {1'b1, 1'b0, 1'b0, 3'd0, 5'd3, 32'd0, 32'd0};
      tests_run++;
      if (obs !== exp) begin tests_failed++; $display("[TB] FAIL reset_wb_ignored: got %h expected %h", obs, exp); end
      tick();
   endtask

   task automatic test_basic_add();
      write_reg(5'd1, 32'd20);
      write_reg(5'd2, 32'd30);
      send(32'h002081B3);
      exp = {1'b1, 1'b0, 1'b0, 3'd0, 5'd3, 32'd20, 32'd30};
      tests_run++;
      if (obs !== exp) begin tests_failed++; $display("[TB] FAIL add: got %h expected %h", obs, exp); end
      tick();
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_consumed: got %b expected 0", out_valid); end
   endtask

   task automatic test_sub_illegal();
      send(32'h402081B3);
      exp = {1'b1, 1'b0, 1'b1, 3'd0, 5'd3, 32'd20, 32'd30};
      tests_run++;
      if (obs !== exp) begin tests_failed++; $display("[TB] FAIL sub: got %h expected %h", obs, exp); end
      send(32'h4020F1B3);
      tests_run++;
      if ({out_valid, illegal} !== 2'b01) begin tests_failed++; $display("[TB] FAIL alt_and_illegal: got %b expected 01", {out_valid, illegal}); end
      tick();
      tests_run++;
      if ({out_valid, illegal} !== 2'b00) begin tests_failed++; $display("[TB] FAIL illegal_pulse_end: got %b expected 00", {out_valid, illegal}); end
   endtask

   task automatic test_immediates();
      send(32'hFFF08293);
      exp = {1'b1, 1'b0, 1'b0, 3'd0, 5'd5, 32'd20, 32'hFFFFFFFF};
      tests_run++;
      if (obs !== exp) begin tests_failed++; $display("[TB] FAIL addi_neg: got %h expected %h", obs, exp); end
      send(32'h4030D293);
      exp = {1'b1, 1'b0, 1'b1, 3'd5, 5'd5, 32'd20, 32'd3};
      tests_run++;
      if (obs !== exp) begin tests_failed++; $display("[TB] FAIL srai: got %h expected %h", obs, exp); end
      send(32'h00309293);
      exp = {1'b1, 1'b0, 1'b0, 3'd1, 5'd5, 32'd20, 32'd3};
      tests_run++;
      if (obs !== exp) begin tests_failed++; $display("[TB] FAIL slli: got %h expected %h", obs, exp); end
      send(32'h40309293);
      tests_run++;
      if ({out_valid, illegal} !== 2'b01) begin tests_failed++; $display("[TB] FAIL slli_alt_illegal: got %b expected 01", {out_valid, illegal}); end
      tick();
   endtask

   task automatic test_bypass_x0();
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd8;
      send(32'h002081B3);
      wb_en = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, 3'd0, 5'd3, 32'd8, 32'd30};
      tests_run++;
      if (obs !== exp) begin tests_failed++; $display("[TB] FAIL bypass: got %h expected %h", obs, exp); end
      write_reg(5'd0, 32'h0000DEAD);
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000BEEF;
      send(32'h000001B3);
      wb_en = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, 3'd0, 5'd3, 32'd0, 32'd0};
      tests_run++;
      if (obs !== exp) begin tests_failed++; $display("[TB] FAIL x0_zero: got %h expected %h", obs, exp); end
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send(32'h002081B3);
      exp = {1'b1, 1'b0, 1'b0, 3'd0, 5'd3, 32'd8, 32'd30};
      in_valid = 1'b1; instr = 32'hFFF08293;
      wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd99;
      for (int c = 0; c < 3; c++) begin
         tests_run++;
         if (obs !== exp || in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hold_cycle%0d: got %h ready %b expected %h ready 0", c, obs, in_ready, exp);
         end
         tick();
         wb_en = 1'b0;
      end
      out_ready = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL release_ready: got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, 3'd0, 5'd5, 32'd8, 32'hFFFFFFFF};
      tests_run++;
      if (obs !== exp) begin tests_failed++; $display("[TB] FAIL queued_accept: got %h expected %h", obs, exp); end
      tick();
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL queued_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_illegal_reset();
      send(32'h00000073);
      tests_run++;
      if ({out_valid, illegal} !== 2'b01) begin tests_failed++; $display("[TB] FAIL ecall: got %b expected 01", {out_valid, illegal}); end
      tick();
      tests_run++;
      if (illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL ecall_pulse_end: got %b expected 0", illegal); end
      out_ready = 1'b0;
      send(32'h002081B3);
      tests_run++;
      if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL pre_reset_valid: got %b expected 1", out_valid); end
      rst = 1'b1; out_ready = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_in_ready: got %b expected 0", in_ready); end
      tick();
      exp = '0;
      tests_run++;
      if (obs !== exp) begin tests_failed++; $display("[TB] FAIL midreset_outputs: got %h expected %h", obs, exp); end
      rst = 1'b0;
      send(32'h002081B3);
      exp = {1'b1, 1'b0, 1'b0, 3'd0, 5'd3, 32'd0, 32'd0};
      tests_run++;
      if (obs !== exp) begin tests_failed++; $display("[TB] FAIL regs_cleared: got %h expected %h", obs, exp); end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_sub_illegal();
      test_immediates();
      test_bypass_x0();
      test_backpressure();
      test_illegal_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
